// File: rtl/vmem_pkg.sv
// Shared constants and helpers for the text video RAM arbiter.
// The RAM address is {row, col}, so columns 80..127 and rows 30..31 are unused cells.
package vmem_pkg;

  localparam int AW       = 12;
  localparam int DW       = 8;
  localparam int COLS     = 80;
  localparam int ROWS     = 30;
  localparam int COL_BITS = 7;
  localparam int ROW_BITS = 5;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_CPU_DONE = 2'd1;
  localparam logic [1:0] ST_CLEAR    = 2'd2;

  typedef logic [AW-1:0]       addr_t;
  typedef logic [DW-1:0]       data_t;
  typedef logic [ROW_BITS-1:0] row_t;
  typedef logic [COL_BITS-1:0] col_t;

  function automatic addr_t cell_addr(input row_t row, input col_t col);
    return {row, col};
  endfunction

endpackage

// File: rtl/vmem_arbiter_if.sv
// CPU memory-mapped port into the video RAM: request held until a one-cycle ack.
interface vmem_arbiter_if;
  import vmem_pkg::*;

  logic  req;
  logic  we;
  addr_t addr;
  data_t wdata;
  logic  ack;
  data_t rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);

endinterface

// File: rtl/vmem_clear_seq.sv
// Row/column walker over the visible text area; wraps to (0,0) after the last cell.
module vmem_clear_seq
  import vmem_pkg::*;
(
  input  logic clk50_in,
  input  logic rst_n,
  input  logic init,
  input  logic advance,
  output row_t row,
  output col_t col,
  output logic last
);

  localparam col_t COL_LAST = col_t'(COLS - 1);
  localparam row_t ROW_LAST = row_t'(ROWS - 1);

  assign last = (row == ROW_LAST) && (col == COL_LAST);

  always_ff @(posedge clk50_in or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (init) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= last ? '0 : row + row_t'(1);
      end else begin
        col <= col + col_t'(1);
      end
    end
  end

endmodule

// File: rtl/vmem_arbiter.sv
// Shares the single-port 4K x 8 text RAM between VGA fetch, CPU port and the clear engine.
// VGA owns every vga_slot=1 cycle; the free cycles go to an active clear, else to the CPU.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting; clear_start wins over a CPU request in a free slot
// CPU_DONE  | CPU access issued last cycle; ack now, read data on ram_rdata
// CLEAR     | filling visible cells, one per free slot; CPU stalled
module vmem_arbiter
  import vmem_pkg::*;
(
  input  logic             clk50_in,
  input  logic             rst_n,
  input  logic             vga_slot,
  input  addr_t            vga_addr,
  output data_t            vga_char,
  vmem_arbiter_if.slave    cpu,
  input  logic             clear_start,
  input  data_t            clear_char,
  output logic             clear_busy,
  output addr_t            ram_addr,
  output logic             ram_we,
  output data_t            ram_wdata,
  input  data_t            ram_rdata
);

  logic [1:0] state;
  logic       op_we;
  logic       vga_slot_q;
  data_t      fill_char;
  data_t      rdata_q;

  row_t       clr_row;
  col_t       clr_col;
  logic       clr_last;

  logic       start_clear;
  logic       issue_cpu;
  logic       clr_write;
  logic       we_raw;

  assign start_clear = (state == ST_IDLE) && clear_start;
  assign issue_cpu   = (state == ST_IDLE) && !clear_start && cpu.req && !vga_slot;
  assign clr_write   = (state == ST_CLEAR) && !vga_slot;

  vmem_clear_seq u_clear_seq (
    .clk50_in (clk50_in),
    .rst_n    (rst_n),
    .init     (start_clear),
    .advance  (clr_write),
    .row      (clr_row),
    .col      (clr_col),
    .last     (clr_last)
  );

  always_comb begin
    ram_addr  = cpu.addr;
    we_raw    = 1'b0;
    ram_wdata = cpu.wdata;
    if (vga_slot) begin
      ram_addr = vga_addr;
    end else if (state == ST_CLEAR) begin
      ram_addr  = cell_addr(clr_row, clr_col);
      we_raw    = 1'b1;
      ram_wdata = fill_char;
    end else if (issue_cpu) begin
      ram_addr  = cpu.addr;
      we_raw    = cpu.we;
      ram_wdata = cpu.wdata;
    end
  end

  // CPU request may be high during reset; keep the RAM from being written then.
  assign ram_we = we_raw & rst_n;

  // Read data arrives during the ack cycle, so it is passed straight through then.
  assign cpu.ack   = (state == ST_CPU_DONE);
  assign cpu.rdata = (state == ST_CPU_DONE && !op_we) ? ram_rdata : rdata_q;

  always_ff @(posedge clk50_in or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      op_we      <= 1'b0;
      vga_slot_q <= 1'b0;
      vga_char   <= '0;
      fill_char  <= '0;
      rdata_q    <= '0;
      clear_busy <= 1'b0;
    end else begin
      // The RAM registers its output, so the fetch issued in a VGA slot lands a cycle later.
      vga_slot_q <= vga_slot;
      if (vga_slot_q) begin
        vga_char <= ram_rdata;
      end

      case (state)
        ST_IDLE: begin
          if (start_clear) begin
            fill_char  <= clear_char;
            clear_busy <= 1'b1;
            state      <= ST_CLEAR;
          end else if (issue_cpu) begin
            op_we <= cpu.we;
            state <= ST_CPU_DONE;
          end
        end
        ST_CPU_DONE: begin
          if (!op_we) begin
            rdata_q <= ram_rdata;
          end
          state <= ST_IDLE;
        end
        ST_CLEAR: begin
          if (clr_write && clr_last) begin
            clear_busy <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          clear_busy <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vmem_arbiter.sv
// Self-checking bench: behavioural RAM plus a shadow copy of its expected contents.
module tb_vmem_arbiter;
  import vmem_pkg::*;

  logic  clk50_in    = 1'b0;
  logic  rst_n       = 1'b0;
  logic  vga_slot    = 1'b0;
  addr_t vga_addr    = '0;
  logic  clear_start = 1'b0;
  data_t clear_char  = '0;
  data_t vga_char;
  logic  clear_busy;
  addr_t ram_addr;
  logic  ram_we;
  data_t ram_wdata;
  data_t ram_rdata   = '0;

  vmem_arbiter_if cpu_bus ();

  vmem_arbiter dut (
    .clk50_in    (clk50_in),
    .rst_n       (rst_n),
    .vga_slot    (vga_slot),
    .vga_addr    (vga_addr),
    .vga_char    (vga_char),
    .cpu         (cpu_bus.slave),
    .clear_start (clear_start),
    .clear_char  (clear_char),
    .clear_busy  (clear_busy),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  initial forever #10 clk50_in = ~clk50_in;

  data_t mem    [0:4095];
  data_t shadow [0:4095];
  logic  ram_init  = 1'b0;
  int    slot_viol = 0;
  int    passes    = 0;
  int    checks    = 0;
  int    slot_mode = 2;   // 0 alternate, 1 stuck high, 2 hold

  function automatic data_t seed_val(input int i);
    return data_t'((i * 37 + 11) ^ (i >> 4));
  endfunction

  always @(posedge clk50_in) begin
    if (!ram_init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= seed_val(i);
      ram_init <= 1'b1;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  always @(negedge clk50_in) begin
    if (rst_n && vga_slot && ram_we) slot_viol++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk50_in);
    #1;
    if (slot_mode == 0) vga_slot = ~vga_slot;
    else if (slot_mode == 1) vga_slot = 1'b1;
  endtask

  task automatic cpu_op(input logic we, input addr_t a, input data_t d, input int budget,
                        output int lat, output data_t rd);
    cpu_bus.we    = we;
    cpu_bus.addr  = a;
    cpu_bus.wdata = d;
    cpu_bus.req   = 1'b1;
    lat = -1;
    rd  = '0;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (cpu_bus.ack) begin
        lat = i;
        rd  = cpu_bus.rdata;
        break;
      end
    end
    cpu_bus.req = 1'b0;
  endtask

  // Alternating slots: the access goes out in the first free slot, ack one cycle later.
  task automatic cpu_checked(input string tag, input logic we, input addr_t a, input data_t d,
                             output data_t rd);
    int exp_lat;
    int lat;
    exp_lat = vga_slot ? 2 : 1;
    cpu_op(we, a, d, 20, lat, rd);
    check({tag, "_lat"}, lat, exp_lat);
    if (we) shadow[a] = d;
    else    check({tag, "_rdata"}, rd, shadow[a]);
    tick();
  endtask

  task automatic vga_check(input string tag, input addr_t a);
    if (!vga_slot) tick();
    vga_addr = a;
    tick();
    tick();
    check(tag, vga_char, shadow[a]);
  endtask

  initial begin
    data_t rd;
    int    lat;
    int    busy_cnt, ack_early, end_cycle, ack_cycle, exp_ack, bad;
    addr_t ra;

    for (int i = 0; i < 4096; i++) shadow[i] = seed_val(i);
    cpu_bus.req   = 1'b1;
    cpu_bus.we    = 1'b1;
    cpu_bus.addr  = 12'h123;
    cpu_bus.wdata = 8'hEE;

    repeat (3) tick();
    check("rst_vga_char", vga_char, 0);
    check("rst_ack", cpu_bus.ack, 0);
    check("rst_busy", clear_busy, 0);
    check("rst_rdata", cpu_bus.rdata, 0);
    check("rst_ram_we", ram_we, 0);

    cpu_bus.req = 1'b0;
    rst_n     = 1'b1;
    slot_mode = 0;
    tick();
    tick();

    cpu_checked("wr_085", 1'b1, 12'h085, 8'h41, rd);
    vga_check("vga_085", 12'h085);

    cpu_checked("wr_0c3", 1'b1, 12'h0C3, 8'h5A, rd);
    cpu_checked("rd_0c3", 1'b0, 12'h0C3, 8'h00, rd);
    check("rdata_hold", cpu_bus.rdata, 8'h5A);

    for (int n = 0; n < 30; n++) begin
      ra = addr_t'($urandom_range(0, 4095));
      cpu_checked("rand_cpu", 1'($urandom_range(0, 1)), ra, data_t'($urandom), rd);
    end
    for (int n = 0; n < 8; n++) begin
      vga_check("rand_vga", addr_t'($urandom_range(0, 4095)));
    end

    // Clear and CPU write collide in one free IDLE slot; a second clear_start mid-clear.
    if (vga_slot) tick();
    clear_char    = 8'h20;
    clear_start   = 1'b1;
    cpu_bus.we    = 1'b1;
    cpu_bus.addr  = 12'h010;
    cpu_bus.wdata = 8'hC7;
    cpu_bus.req   = 1'b1;
    tick();
    clear_start = 1'b0;
    clear_char  = 8'h99;
    check("collide_busy", clear_busy, 1);
    check("collide_noack", cpu_bus.ack, 0);
    busy_cnt = 0; ack_early = 0; end_cycle = -1; ack_cycle = -1; exp_ack = -2;
    for (int c = 1; c <= 6000; c++) begin
      if (clear_busy) busy_cnt++;
      else if (end_cycle < 0) begin
        end_cycle = c;
        exp_ack   = c + (vga_slot ? 2 : 1);
      end
      if (cpu_bus.ack) begin
        if (clear_busy) ack_early++;
        ack_cycle = c;
        break;
      end
      clear_start = (c == 1000);
      if (c == 1000) clear_char = 8'h33;
      tick();
    end
    cpu_bus.req = 1'b0;
    clear_start = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        shadow[cell_addr(row_t'(r), col_t'(c))] = 8'h20;
    shadow[12'h010] = 8'hC7;
    check("clear_busy_cycles", busy_cnt, 4800);
    check("clear_ack_early", ack_early, 0);
    check("clear_ack_cycle", ack_cycle, exp_ack);
    check("clear_000", mem[12'h000], 8'h20);
    check("clear_ecf", mem[12'hECF], 8'h20);
    check("clear_050", mem[12'h050], shadow[12'h050]);
    check("clear_f00", mem[12'hF00], shadow[12'hF00]);
    check("clear_010", mem[12'h010], 8'hC7);
    bad = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== shadow[i]) bad++;
    check("clear_sweep", bad, 0);
    tick();
    cpu_checked("rd_010", 1'b0, 12'h010, 8'h00, rd);

    // VGA slot stuck high starves the CPU; service resumes once slots free up.
    slot_mode = 1;
    vga_slot  = 1'b1;
    cpu_op(1'b0, 12'h0C3, 8'h00, 50, lat, rd);
    check("stuck_noack", lat, 32'hFFFF_FFFF);
    slot_mode = 0;
    tick();
    tick();
    cpu_checked("unstuck_rd", 1'b0, 12'h0C3, 8'h00, rd);

    // Reset in the middle of a clear.
    vga_addr = 12'hECF;
    if (vga_slot) tick();
    clear_char  = 8'h55;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    repeat (100) tick();
    check("pre_rst_vga", vga_char, 8'h20);
    check("pre_rst_busy", clear_busy, 1);
    #5;
    rst_n = 1'b0;
    #1;
    check("async_rst_vga", vga_char, 0);
    check("async_rst_busy", clear_busy, 0);
    check("async_rst_ack", cpu_bus.ack, 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) shadow[i] = 8'h55;
    check("abort_first", mem[12'h000], 8'h55);
    check("abort_049", mem[12'h031], 8'h55);
    check("abort_050", mem[12'h032], 8'h20);
    check("abort_ecf", mem[12'hECF], 8'h20);
    tick();
    cpu_checked("post_rst_rd", 1'b0, 12'h000, 8'h00, rd);
    vga_check("post_rst_vga", 12'h031);
    check("slot_never_written", slot_viol, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/vmem_arbiter.md
Name: vmem_arbiter

Overview:
Owns the single-port 4K x 8 text video RAM and shares it between three users: the VGA character fetch, the LC-3 CPU memory-mapped port, and an internal clear-screen engine.
- VGA owns the RAM in every cycle where vga_slot=1, the clk25-high phase of the VGA timing.
- CPU accesses and clear writes use the remaining cycles.
- Sits between the VGA text controller, the CPU bus decode and the video RAM.

Parameters:
AW, 12, RAM address width ({row[4:0], col[6:0]})
DW, 8, character width
COLS, 80, visible text columns
ROWS, 30, visible text rows

Ports:
clk50_in  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
vga_slot  in  1  1 = VGA owns the RAM this cycle
vga_addr  in  AW  VGA character fetch address
vga_char  out  DW  registered character for the VGA
cpu_req  in  1  CPU request; held with addr/we/wdata until ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  AW  CPU address; any value is legal, including unused cells
cpu_wdata  in  DW  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DW  read data, valid while cpu_ack=1 and held afterwards
clear_start  in  1  pulse: fill all visible cells with clear_char
clear_char  in  DW  fill character, sampled when clear_start is accepted
clear_busy  out  1  clear in progress
ram_addr  out  AW  RAM address (combinational mux)
ram_we  out  1  RAM write enable
ram_wdata  out  DW  RAM write data
ram_rdata  in  DW  RAM read data, one cycle after ram_addr

Behaviour:
- Reset (async, rst_n=0) forces:
  - state=IDLE;
  - vga_char, cpu_rdata, cpu_ack, clear_busy = 0;
  - clear counters = 0.
  - ram_we is 0 while in reset.
  - Reset during a clear aborts it; cells already written stay written.
- Slot with vga_slot=1:
  - ram_addr=vga_addr, ram_we=0.
  - On the next edge, vga_char <= ram_rdata, giving 1-cycle latency; vga_char holds otherwise.
- Free slot (vga_slot=0) is given to the first match, in this order:
  1. CLEAR state.
  2. An accepted CPU request.
  3. Otherwise ram_we=0 and ram_addr=cpu_addr.
- FSM states: IDLE, CPU_DONE, CLEAR.
- IDLE:
  - clear_start=1 → CLEAR. Latch clear_char, row=0, col=0, clear_busy=1. clear_start takes priority over cpu_req in the same cycle.
  - Otherwise cpu_req=1 in a free slot issues the access: ram_addr=cpu_addr, ram_we=cpu_we, ram_wdata=cpu_wdata → CPU_DONE.
- CPU_DONE, one cycle:
  - cpu_ack=1.
  - For a read, cpu_rdata <= ram_rdata.
  - → IDLE.
  - No new CPU access is issued in the ack cycle. A request still high after ack is treated as a new request.
- CLEAR:
  - Each free slot writes the latched char at {row, col}, then col++.
  - When col=COLS-1: col=0, row++.
  - The write at row=ROWS-1, col=COLS-1 is the last: clear_busy drops on the next edge → IDLE.
  - Exactly 2400 writes. Addresses with col≥80 or row≥30 are never touched.
  - clear_start during CLEAR is ignored.
  - cpu_req is stalled (no ack) until CLEAR ends, then served normally.
- vga_slot stuck at 1 starves the CPU and clear; this is legal and there is no timeout.
- Arbitration does not depend on vga_slot strictly alternating.

Decomposition:
- Shared package vmem_pkg:
  - AW, DW, COLS, ROWS, COL_BITS=7, ROW_BITS=5;
  - state encoding: IDLE=2'd0, CPU_DONE=2'd1, CLEAR=2'd2.
- One natural sub-module: vmem_clear_seq, the row/col counter with a last-cell flag. It advances on an enable.

Test Plan:
- Reset: rst_n low mid-operation → vga_char=0, cpu_ack=0, clear_busy=0 immediately, without waiting for a clock edge.
- VGA fetch: RAM[0x085]=0x41, vga_slot=1, vga_addr=0x085 → vga_char=0x41 one cycle later. RAM is never written in VGA slots.
- CPU write then read, vga_slot alternating:
  - write 0x5A to 0x0C3 → ack 1 cycle after the free slot;
  - read 0x0C3 → cpu_rdata=0x5A in the ack cycle.
- Clear with clear_char=0x20:
  - clear_busy=1 for exactly 4800 cycles under alternating slots;
  - RAM[0x000]=RAM[0xECF]=0x20;
  - RAM[0x050] and RAM[0xF00] unchanged.
- CPU write to 0x010 during a clear → no ack until clear_busy falls; ack follows; final RAM[0x010]=CPU data.
- clear_start and cpu_req in the same IDLE free slot → clear wins. A second clear_start mid-clear does not restart the clear (same 4800-cycle total).
